// File: rtl/snd_att_mixer.sv
// -----------------------------------------------------------------------------
// snd_att_mixer
//
// Runtime-programmable N-channel audio attenuator/mixer. Each channel has its
// own MUL/DIV gain pair, written into shadow registers at any time and copied
// into the active set when a sample strobe is accepted. One multiplier and one
// restoring divider are shared across the channels. The signed quotients are
// summed into a wide accumulator and then clamped to a single OUT_WIDTH sample.
//
// Sequence per mix:
//   IDLE -> START -> (MUL -> DIV x DW -> ACC) x CH_NUM -> SAT -> IDLE
// START is one setup cycle that clears the accumulator and the channel index.
// The latency from the accepting edge to OUT_VALID is therefore
// 1 + CH_NUM*(DW+2) + 1 cycles.
//
// Optional build macro: SND_ATT_MIXER_CLIP_CNT_EN
//   When defined, the module adds an 8-bit saturating CLIP_CNT output.
//
// Ports:
//   CLK         system clock
//   RESET_n     synchronous active-low reset
//   SAMPLE_STB  one-cycle pulse; starts a mix when IDLE
//   CH_IN       packed signed samples, channel k at [k*IN_WIDTH +: IN_WIDTH]
//   REG_WE      gain shadow register write strobe
//   REG_CH      target channel of the write (>= CH_NUM is ignored)
//   REG_MUL     multiplier value
//   REG_DIV     divisor value (0 mutes the channel)
//   OVR_CLR     clears OVERRUN (and CLIP_CNT when enabled)
//   OUT         signed mixed sample, held between updates
//   OUT_VALID   one-cycle pulse when OUT updates
//   BUSY        mix in progress
//   CLIPPED     last OUT was saturated
//   OVERRUN     sticky: a strobe arrived while busy
//   CLIP_CNT    (optional) saturating count of clipped outputs
// -----------------------------------------------------------------------------
module snd_att_mixer #(
    parameter int CH_NUM     = 4,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int GAIN_WIDTH = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_n,
    input  logic                          SAMPLE_STB,
    input  logic [CH_NUM*IN_WIDTH-1:0]    CH_IN,
    input  logic                          REG_WE,
    input  logic [2:0]                    REG_CH,
    input  logic [GAIN_WIDTH-1:0]         REG_MUL,
    input  logic [GAIN_WIDTH-1:0]         REG_DIV,
    input  logic                          OVR_CLR,
    output logic signed [OUT_WIDTH-1:0]   OUT,
    output logic                          OUT_VALID,
    output logic                          BUSY,
    output logic                          CLIPPED,
`ifdef SND_ATT_MIXER_CLIP_CNT_EN
    output logic                          OVERRUN,
    output logic [7:0]                    CLIP_CNT
`else
    output logic                          OVERRUN
`endif
);

    localparam int DW    = IN_WIDTH + GAIN_WIDTH;
    localparam int ACC_W = DW + $clog2(CH_NUM) + 1;
    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CNT_W = $clog2(DW + 1);

    // Clamp limits in accumulator width; the minimum is the bitwise inverse
    // of the maximum (-max-1 in two's complement).
    localparam logic signed [ACC_W-1:0] OUT_MAX_A = ACC_W'((64'd1 << (OUT_WIDTH-1)) - 64'd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN_A = ~OUT_MAX_A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_MUL,
        S_DIV,
        S_ACC,
        S_SAT
    } state_t;

    state_t                       state;
    logic [CH_NUM*IN_WIDTH-1:0]   ch_lat;
    logic [GAIN_WIDTH-1:0]        mul_sh  [CH_NUM];
    logic [GAIN_WIDTH-1:0]        div_sh  [CH_NUM];
    logic [GAIN_WIDTH-1:0]        mul_act [CH_NUM];
    logic [GAIN_WIDTH-1:0]        div_act [CH_NUM];
    logic [IDX_W-1:0]             idx;
    logic signed [ACC_W-1:0]      acc;
    logic                         neg;
    // Dividend shifts out MSB-first while quotient bits shift in at the LSB,
    // so after DW steps this register holds |p| / DIV.
    logic [DW-1:0]                dvd;
    logic [GAIN_WIDTH-1:0]        rem;
    logic [CNT_W-1:0]             bit_cnt;

    // ---------------- datapath (combinational) ----------------
    logic signed [IN_WIDTH-1:0]   x_cur;
    logic [GAIN_WIDTH-1:0]        mul_cur;
    logic [GAIN_WIDTH-1:0]        div_cur;
    logic signed [DW:0]           prod;
    logic [DW-1:0]                p_mag;
    logic [GAIN_WIDTH:0]          rem_sh;
    logic [GAIN_WIDTH:0]          div_ext;
    logic                         ge;
    logic [GAIN_WIDTH-1:0]        rem_nx;
    logic [DW-1:0]                dvd_nx;
    logic signed [ACC_W-1:0]      q_ext;
    logic signed [ACC_W-1:0]      q_signed;
    logic                         sat_hi;
    logic                         sat_lo;
    logic                         clip_now;

    always_comb begin
        x_cur    = ch_lat[idx*IN_WIDTH +: IN_WIDTH];
        mul_cur  = mul_act[idx];
        div_cur  = div_act[idx];

        // Both operands sign/zero-extended to DW+1 so the product is exact.
        prod     = $signed({{(DW+1-IN_WIDTH){x_cur[IN_WIDTH-1]}}, x_cur})
                 * $signed({{(DW+1-GAIN_WIDTH){1'b0}}, mul_cur});
        p_mag    = prod[DW] ? DW'(-prod) : prod[DW-1:0];

        // One restoring-division step. The partial remainder is always below
        // the divisor, so GAIN_WIDTH bits hold it between steps.
        rem_sh   = {rem, dvd[DW-1]};
        div_ext  = {1'b0, div_cur};
        ge       = (rem_sh >= div_ext);
        rem_nx   = ge ? GAIN_WIDTH'(rem_sh - div_ext) : rem_sh[GAIN_WIDTH-1:0];
        dvd_nx   = {dvd[DW-2:0], ge};

        // Quotient is a magnitude; reapplying the sign truncates toward zero.
        q_ext    = {{(ACC_W-DW){1'b0}}, dvd};
        q_signed = neg ? -q_ext : q_ext;

        sat_hi   = (acc > OUT_MAX_A);
        sat_lo   = (acc < OUT_MIN_A);
        clip_now = (state == S_SAT) && (sat_hi || sat_lo);
    end

    // ---------------- control and registers ----------------
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state     <= S_IDLE;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            CLIPPED   <= 1'b0;
            OVERRUN   <= 1'b0;
            ch_lat    <= '0;
            idx       <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            dvd       <= '0;
            rem       <= '0;
            bit_cnt   <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                mul_sh[k]  <= GAIN_WIDTH'(1);
                div_sh[k]  <= GAIN_WIDTH'(1);
                mul_act[k] <= GAIN_WIDTH'(1);
                div_act[k] <= GAIN_WIDTH'(1);
            end
        end else begin
            OUT_VALID <= 1'b0;

            if (REG_WE && (32'(REG_CH) < CH_NUM)) begin
                mul_sh[REG_CH[IDX_W-1:0]] <= REG_MUL;
                div_sh[REG_CH[IDX_W-1:0]] <= REG_DIV;
            end

            // A dropped strobe takes priority over the clear.
            if (SAMPLE_STB && (state != S_IDLE))
                OVERRUN <= 1'b1;
            else if (OVR_CLR)
                OVERRUN <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (SAMPLE_STB) begin
                        // Shadow values read here are the pre-write ones, so a
                        // same-cycle register write waits for the next strobe.
                        ch_lat <= CH_IN;
                        for (int k = 0; k < CH_NUM; k++) begin
                            mul_act[k] <= mul_sh[k];
                            div_act[k] <= div_sh[k];
                        end
                        BUSY  <= 1'b1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    acc   <= '0;
                    idx   <= '0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    neg     <= prod[DW];
                    dvd     <= p_mag;
                    rem     <= '0;
                    bit_cnt <= '0;
                    state   <= S_DIV;
                end
                S_DIV: begin
                    rem     <= rem_nx;
                    dvd     <= dvd_nx;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(DW-1))
                        state <= S_ACC;
                end
                S_ACC: begin
                    // DIV=0 runs the divider anyway for constant timing, but
                    // its result is discarded so the channel is muted.
                    if (div_cur != '0)
                        acc <= acc + q_signed;
                    if (idx == IDX_W'(CH_NUM-1)) begin
                        state <= S_SAT;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_MUL;
                    end
                end
                S_SAT: begin
                    if (sat_hi)
                        OUT <= OUT_MAX_A[OUT_WIDTH-1:0];
                    else if (sat_lo)
                        OUT <= OUT_MIN_A[OUT_WIDTH-1:0];
                    else
                        OUT <= acc[OUT_WIDTH-1:0];
                    CLIPPED   <= sat_hi || sat_lo;
                    OUT_VALID <= 1'b1;
                    BUSY      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SND_ATT_MIXER_CLIP_CNT_EN
    // Saturating clip counter; a clip in the clearing cycle still counts.
    always_ff @(posedge CLK) begin
        if (!RESET_n)
            CLIP_CNT <= 8'd0;
        else if (OVR_CLR)
            CLIP_CNT <= clip_now ? 8'd1 : 8'd0;
        else if (clip_now && (CLIP_CNT != 8'hFF))
            CLIP_CNT <= CLIP_CNT + 8'd1;
    end
`endif

endmodule
